// File: rtl/wb_scheduler_pkg.sv
// rtl/wb_scheduler_pkg.sv - shared constants and helpers for the write-back scheduler
package wb_scheduler_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NUM   = 64;
    localparam int DEF_AW    = 6;
    localparam int DEF_NREQ  = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_FPU = 2'd1,
        WB_MEM = 2'd2
    } wb_src_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/wb_scheduler_rr_arbiter.sv
// rtl/wb_scheduler_rr_arbiter.sv - round-robin arbiter with rotating priority pointer
module rr_arbiter
    import wb_scheduler_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    // Scan from ptr upward; the first requester found wins and ptr moves past it.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'(rr_next(idx, N));
                found    = 1'b1;
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// rtl/wb_scheduler.sv - shares the register bank write port and tracks pending writes
module wb_scheduler
    import wb_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM   = DEF_NUM,
    parameter int AW    = DEF_AW,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NUM-1:0]        wr_enable,
    output logic [WIDTH-1:0]      wr_data,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic [AW-1:0]         iss_rs1,
    input  logic [AW-1:0]         iss_rs2,
    output logic                  iss_ready,
    output logic [NUM-1:0]        busy,
    output logic                  err_wb
);

    logic [NREQ-1:0]  gnt;
    logic             any_gnt;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    logic [NUM-1:0]   wr_enable_q, wr_enable_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM-1:0]   busy_q, busy_d;
    logic             err_wb_q, err_wb_d;
    logic [NUM-1:0]   iss_set;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Writes to r0 still drain the requester but never reach the bank or scoreboard.
    always_comb begin
        wr_enable_d = '0;
        wr_data_d   = '0;
        err_wb_d    = err_wb_q;
        if (any_gnt) begin
            wr_data_d = sel_data;
            if (sel_addr != '0) begin
                wr_enable_d[sel_addr] = 1'b1;
                if (!busy_q[sel_addr]) begin
                    err_wb_d = 1'b1;
                end
            end
        end
    end

    assign iss_ready = !rst && !busy_q[iss_rs1] && !busy_q[iss_rs2] &&
                       ((iss_rd == '0) || !busy_q[iss_rd]);

    // A bit clears on the edge its bank write lands; a new issue on that edge wins.
    always_comb begin
        iss_set = '0;
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            iss_set[iss_rd] = 1'b1;
        end
        busy_d    = (busy_q & ~wr_enable_q) | iss_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_enable_q <= '0;
            wr_data_q   <= '0;
            busy_q      <= '0;
            err_wb_q    <= 1'b0;
        end else begin
            wr_enable_q <= wr_enable_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            err_wb_q    <= err_wb_d;
        end
    end

    assign wr_enable = wr_enable_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign err_wb    = err_wb_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// tb/tb_wb_scheduler.sv - scoreboard bench for wb_scheduler against a behavioural model
module tb_wb_scheduler;

    localparam int WIDTH = 32;
    localparam int NUM   = 64;
    localparam int AW    = 6;
    localparam int NREQ  = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NUM-1:0]        wr_enable;
    logic [WIDTH-1:0]      wr_data;
    logic                  iss_valid;
    logic [AW-1:0]         iss_rd, iss_rs1, iss_rs2;
    logic                  iss_ready;
    logic [NUM-1:0]        busy;
    logic                  err_wb;

    always #5 clk = ~clk;

    wb_scheduler #(.WIDTH(WIDTH), .NUM(NUM), .AW(AW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_enable (wr_enable),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_ready (iss_ready),
        .busy      (busy),
        .err_wb    (err_wb)
    );

    typedef struct {
        logic [NUM-1:0]   en;
        logic [WIDTH-1:0] data;
        bit               chk_data;
        logic [NUM-1:0]   bsy;
        bit               err;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;

    // Reference state: which registers await a write, pointer, sticky error, write in flight.
    bit m_busy[NUM];
    int m_ptr;
    bit m_err;
    int m_infl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                        input logic [NREQ*WIDTH-1:0] d, input bit iv, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, output int g);
        exp_t             e;
        bit               ir;
        int               ga;
        logic [WIDTH-1:0] gd;
        logic [NREQ-1:0]  eg;
        @(negedge clk);
        rst = r; req_valid = v; req_addr = a; req_data = d;
        iss_valid = iv; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
        #1;
        g = -1;
        if (!r) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (m_ptr + k) % NREQ;
                if (g < 0 && v[i]) g = i;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        ir = !r && !m_busy[rs1] && !m_busy[rs2] && (rd == 0 || !m_busy[rd]);
        check("req_ready", 64'(req_ready), 64'(eg));
        check("iss_ready", 64'(iss_ready), 64'(ir));
        e.en = '0; e.data = '0; e.chk_data = 1'b1;
        if (r) begin
            foreach (m_busy[n]) m_busy[n] = 1'b0;
            m_ptr = 0; m_err = 1'b0; m_infl = -1;
        end else begin
            ga = 0; gd = '0;
            if (g >= 0) begin
                ga = int'(a[g*AW +: AW]);
                gd = d[g*WIDTH +: WIDTH];
                e.data = gd;
                e.chk_data = (ga != 0);
                if (ga != 0) begin
                    e.en = 64'd1 << ga;
                    if (!m_busy[ga]) m_err = 1'b1;
                end
                m_ptr = (g + 1) % NREQ;
            end
            if (m_infl > 0) m_busy[m_infl] = 1'b0;
            if (iv && ir && rd != 0) m_busy[rd] = 1'b1;
            m_infl = (g >= 0 && ga != 0) ? ga : -1;
        end
        for (int n = 0; n < NUM; n++) e.bsy[n] = m_busy[n];
        e.err = m_err;
        expq.push_back(e);
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL queue_underflow: got empty expected entry at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    check("wr_enable", wr_enable, e.en);
                    check("busy", busy, e.bsy);
                    check("err_wb", 64'(err_wb), 64'(e.err));
                    if (e.chk_data) check("wr_data", 64'(wr_data), 64'(e.data));
                end
            end
        end
    end

    function automatic logic [NREQ*AW-1:0] pa(input int a0, input int a1, input int a2);
        return {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] pd(input logic [WIDTH-1:0] d0,
                                                 input logic [WIDTH-1:0] d1,
                                                 input logic [WIDTH-1:0] d2);
        return {d2, d1, d0};
    endfunction

    bit               pv[NREQ];
    int               pad[NREQ];
    logic [WIDTH-1:0] pdat[NREQ];

    initial begin : driver
        int                    g;
        int                    bl[$];
        logic [NREQ-1:0]       v;
        logic [NREQ*AW-1:0]    a;
        logic [NREQ*WIDTH-1:0] d;
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, g);
        // Single write: issue r5, ALU writes it back.
        step(0, 0, 0, 0, 1, 5, 0, 0, g);
        step(0, 3'b001, pa(5, 0, 0), pd(32'hDEADBEEF, 0, 0), 0, 0, 0, 0, g);
        repeat (2) step(0, 0, 0, 0, 1, 6, 5, 0, g);
        // Reset mid-stream with busy bits set.
        step(0, 0, 0, 0, 1, 12, 0, 0, g);
        step(1, 3'b111, pa(3, 4, 5), pd(1, 2, 3), 1, 13, 0, 0, g);
        // Round-robin: all valid, then requester 1 dropped.
        repeat (6) step(0, 3'b111, pa(10, 20, 33), pd(32'h11, 32'h22, 32'h33), 0, 0, 0, 0, g);
        repeat (4) step(0, 3'b101, pa(10, 20, 33), pd(32'h11, 32'h22, 32'h33), 0, 0, 0, 0, g);
        step(1, 0, 0, 0, 0, 0, 0, 0, g);
        // Hazard: rd=40 pending, RAW and WAW stalled until FPU write-back.
        step(0, 0, 0, 0, 1, 40, 0, 0, g);
        repeat (3) step(0, 0, 0, 0, 1, 41, 40, 0, g);
        step(0, 0, 0, 0, 1, 40, 0, 0, g);
        step(0, 3'b010, pa(0, 40, 0), pd(0, 32'hF00D, 0), 1, 41, 40, 0, g);
        repeat (3) step(0, 0, 0, 0, 1, 41, 40, 0, g);
        // Zero register drained by MEM.
        step(0, 3'b100, pa(0, 0, 0), pd(0, 0, 32'h1234), 0, 0, 0, 0, g);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, g);
        // Write-back to non-busy r7, then same-edge set/clear of r9.
        step(0, 3'b001, pa(7, 0, 0), pd(32'h77, 0, 0), 0, 0, 0, 0, g);
        step(0, 3'b001, pa(9, 0, 0), pd(32'h99, 0, 0), 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 1, 9, 0, 0, g);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, g);
        step(1, 0, 0, 0, 0, 0, 0, 0, g);
        // Randomised traffic with requesters holding until granted.
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            bl.delete();
            for (int n = 1; n < NUM; n++) if (m_busy[n]) bl.push_back(n);
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 40) begin
                    pv[i] = 1'b1;
                    if (bl.size() > 0 && $urandom_range(0, 99) < 85)
                        pad[i] = bl[$urandom_range(0, bl.size() - 1)];
                    else
                        pad[i] = $urandom_range(0, NUM - 1);
                    pdat[i] = $urandom;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                v[i] = pv[i];
                a[i*AW +: AW] = AW'(pad[i]);
                d[i*WIDTH +: WIDTH] = pdat[i];
            end
            step((c == 700) ? 1'b1 : 1'b0, v, a, d, ($urandom_range(0, 99) < 60),
                 AW'($urandom_range(0, 1) * 32 + $urandom_range(0, 7)),
                 AW'($urandom_range(0, 1) * 32 + $urandom_range(0, 7)),
                 AW'($urandom_range(0, 1) * 32 + $urandom_range(0, 7)), g);
            if (c == 700) begin
                for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
            end else if (g >= 0) begin
                pv[g] = 1'b0;
            end
        end
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
